ysyx_24100005_regfile_reader: RTL and testbench

Read-side companion to the core's write-only register file: a storage array with a writeback port, plus a handshaked two-source read port.
- Decode issues {rs1, rs2, optional rd reservation}; the block returns both operands one cycle later through a registered valid/ready response.
- A per-register busy scoreboard stalls reads of registers with pending writebacks; same-cycle writeback data is forwarded.
- Sits between IDU (request side) and EXU (response side); WBU drives the writeback port.

---
 rtl/ysyx_24100005_regfile_reader_pkg.sv | 11 +
 rtl/ysyx_24100005_regfile_reader_scoreboard.sv | 44 ++++
 rtl/ysyx_24100005_regfile_reader.sv | 90 +++++++++
 tb/tb_ysyx_24100005_regfile_reader.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24100005_regfile_reader_pkg.sv
// Shared register-file widths and index/data typedefs.
// Used by the reader, its scoreboard and the rest of the core.
package ysyx_24100005_regfile_reader_pkg;

  localparam int RF_ADDR_WIDTH = 5;
  localparam int RF_DATA_WIDTH = 32;

  typedef logic [RF_ADDR_WIDTH-1:0] reg_idx_t;
  typedef logic [RF_DATA_WIDTH-1:0] xlen_t;

endpackage

// File: rtl/ysyx_24100005_regfile_reader_scoreboard.sv
// Per-register busy bits for pending writebacks.
// A same-cycle writeback satisfies a busy source.
module ysyx_24100005_scoreboard
  import ysyx_24100005_regfile_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_en,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic                  set_en,
  input  logic [ADDR_WIDTH-1:0] set_addr,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  output logic                  ok_rs1,
  output logic                  ok_rs2
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DEPTH-1:0] busy;
  logic             wb_hit;
  logic             set_hit;

  assign wb_hit  = wb_en && (wb_addr != '0);
  assign set_hit = set_en && (set_addr != '0);

  // Set is applied last so a new reservation beats a same-index clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
    end else begin
      if (wb_hit) busy[wb_addr] <= 1'b0;
      if (set_hit) busy[set_addr] <= 1'b1;
    end
  end

  assign ok_rs1 = (rs1 == '0) || !busy[rs1] ||
                  (wb_en && (wb_addr == rs1));
  assign ok_rs2 = (rs2 == '0) || !busy[rs2] ||
                  (wb_en && (wb_addr == rs2));

endmodule

// File: rtl/ysyx_24100005_regfile_reader.sv
// Register array with writeback port and handshaked
// two-source read port backed by a one-entry output stage.
module ysyx_24100005_regfile_reader
  import ysyx_24100005_regfile_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int DATA_WIDTH = RF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_rs1,
  input  logic [ADDR_WIDTH-1:0] req_rs2,
  input  logic                  req_rd_alloc,
  input  logic [ADDR_WIDTH-1:0] req_rd,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rs1_data,
  output logic [DATA_WIDTH-1:0] rsp_rs2_data,
  input  logic                  wb_en,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [0:0]            state;
  logic                  ok_rs1;
  logic                  ok_rs2;
  logic                  accept;
  logic [DATA_WIDTH-1:0] rs1_val;
  logic [DATA_WIDTH-1:0] rs2_val;

  always_ff @(posedge clk) begin
    if (wb_en && (wb_addr != '0)) mem[wb_addr] <= wb_data;
  end

  ysyx_24100005_scoreboard #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_sb (
    .clk     (clk),
    .rst     (rst),
    .wb_en   (wb_en),
    .wb_addr (wb_addr),
    .set_en  (accept && req_rd_alloc),
    .set_addr(req_rd),
    .rs1     (req_rs1),
    .rs2     (req_rs2),
    .ok_rs1  (ok_rs1),
    .ok_rs2  (ok_rs2)
  );

  assign rsp_valid = (state == FULL);
  assign req_ready = rst && ok_rs1 && ok_rs2 &&
                     (!rsp_valid || rsp_ready);
  assign accept    = req_valid && req_ready;

  always_comb begin
    rs1_val = '0;
    if (req_rs1 == '0) rs1_val = '0;
    else if (wb_en && (wb_addr == req_rs1)) rs1_val = wb_data;
    else rs1_val = mem[req_rs1];
  end

  always_comb begin
    rs2_val = '0;
    if (req_rs2 == '0) rs2_val = '0;
    else if (wb_en && (wb_addr == req_rs2)) rs2_val = wb_data;
    else rs2_val = mem[req_rs2];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= EMPTY;
      rsp_rs1_data <= '0;
      rsp_rs2_data <= '0;
    end else if (accept) begin
      state        <= FULL;
      rsp_rs1_data <= rs1_val;
      rsp_rs2_data <= rs2_val;
    end else if (rsp_ready) begin
      state <= EMPTY;
    end
  end

endmodule

// File: tb/tb_ysyx_24100005_regfile_reader.sv
// Directed bench for the regfile reader: forwarding, hazards,
// backpressure, throughput, x0 and async reset.
module tb_ysyx_24100005_regfile_reader;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_rs1;
  logic [4:0]  req_rs2;
  logic        req_rd_alloc;
  logic [4:0]  req_rd;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rs1_data;
  logic [31:0] rsp_rs2_data;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  int pass_cnt;
  int total_cnt;

  ysyx_24100005_regfile_reader dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_rs1     (req_rs1),
    .req_rs2     (req_rs2),
    .req_rd_alloc(req_rd_alloc),
    .req_rd      (req_rd),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rs1_data(rsp_rs1_data),
    .rsp_rs2_data(rsp_rs2_data),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_wb(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    @(posedge clk);
    #1;
    wb_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; req_valid = 1'b1;
    #12;
    total_cnt++;
    if (rsp_valid !== 1'b0)
      $display("FAIL rst_valid got %b exp 0", rsp_valid);
    else pass_cnt++;
    total_cnt++;
    if (rsp_rs1_data !== 32'h0 || rsp_rs2_data !== 32'h0)
      $display("FAIL rst_data got %h/%h exp 0/0",
               rsp_rs1_data, rsp_rs2_data);
    else pass_cnt++;
    total_cnt++;
    if (req_ready !== 1'b0)
      $display("FAIL rst_ready got %b exp 0", req_ready);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b0;
  endtask

  task automatic test_basic();
    do_wb(5'd5, 32'hDEADBEEF);
    @(negedge clk);
    req_valid = 1'b1; req_rs1 = 5'd5; req_rs2 = 5'd0;
    rsp_ready = 1'b1;
    #1;
    total_cnt++;
    if (req_ready !== 1'b1)
      $display("FAIL basic_ready got %b exp 1", req_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (rsp_valid !== 1'b1)
      $display("FAIL basic_valid got %b exp 1", rsp_valid);
    else pass_cnt++;
    total_cnt++;
    if (rsp_rs1_data !== 32'hDEADBEEF || rsp_rs2_data !== 32'h0)
      $display("FAIL basic_data got %h/%h exp deadbeef/0",
               rsp_rs1_data, rsp_rs2_data);
    else pass_cnt++;
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk); #1;
    total_cnt++;
    if (rsp_valid !== 1'b0)
      $display("FAIL basic_drain got %b exp 0", rsp_valid);
    else pass_cnt++;
  endtask

  task automatic test_hazard();
    @(negedge clk);
    req_valid = 1'b1; req_rs1 = 5'd0; req_rs2 = 5'd0;
    req_rd_alloc = 1'b1; req_rd = 5'd7;
    @(posedge clk); #1;
    @(negedge clk);
    req_rd_alloc = 1'b0; req_rs1 = 5'd7;
    for (int k = 0; k < 3; k++) begin
      #1;
      total_cnt++;
      if (req_ready !== 1'b0)
        $display("FAIL hazard_stall%0d got %b exp 0", k, req_ready);
      else pass_cnt++;
      @(negedge clk);
    end
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h1234;
    #1;
    total_cnt++;
    if (req_ready !== 1'b1)
      $display("FAIL hazard_release got %b exp 1", req_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (rsp_valid !== 1'b1 || rsp_rs1_data !== 32'h1234)
      $display("FAIL hazard_fwd got %b/%h exp 1/00001234",
               rsp_valid, rsp_rs1_data);
    else pass_cnt++;
    @(negedge clk);
    wb_en = 1'b0; req_valid = 1'b0;
  endtask

  task automatic test_stall();
    do_wb(5'd9, 32'hAAAA);
    @(negedge clk);
    req_valid = 1'b1; req_rs1 = 5'd9; req_rs2 = 5'd5;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if (rsp_rs1_data !== 32'hAAAA || rsp_rs2_data !== 32'hDEADBEEF)
      $display("FAIL stall_first got %h/%h exp 0000aaaa/deadbeef",
               rsp_rs1_data, rsp_rs2_data);
    else pass_cnt++;
    @(negedge clk);
    rsp_ready = 1'b0; req_rs1 = 5'd5; req_rs2 = 5'd0;
    wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h5555;
    for (int k = 0; k < 3; k++) begin
      #1;
      total_cnt++;
      if (req_ready !== 1'b0)
        $display("FAIL stall_ready%0d got %b exp 0", k, req_ready);
      else pass_cnt++;
      @(posedge clk); #1;
      total_cnt++;
      if (rsp_valid !== 1'b1 || rsp_rs1_data !== 32'hAAAA ||
          rsp_rs2_data !== 32'hDEADBEEF)
        $display("FAIL stall_hold%0d got %b %h/%h exp 1 aaaa/deadbeef",
                 k, rsp_valid, rsp_rs1_data, rsp_rs2_data);
      else pass_cnt++;
      @(negedge clk);
      wb_en = 1'b0;
    end
    rsp_ready = 1'b1;
    #1;
    total_cnt++;
    if (req_ready !== 1'b1)
      $display("FAIL stall_resume got %b exp 1", req_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (rsp_rs1_data !== 32'hDEADBEEF || rsp_rs2_data !== 32'h0)
      $display("FAIL stall_next got %h/%h exp deadbeef/0",
               rsp_rs1_data, rsp_rs2_data);
    else pass_cnt++;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] e1;
    logic [31:0] e2;
    for (int i = 0; i < 8; i++)
      do_wb(5'(16 + i), 32'h100 + 32'(i * 3));
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      req_valid = 1'b1; req_rs1 = 5'(16 + i);
      req_rs2 = (i % 2 == 1) ? 5'd5 : 5'd0;
      e1 = 32'h100 + 32'(i * 3);
      e2 = (i % 2 == 1) ? 32'hDEADBEEF : 32'h0;
      #1;
      total_cnt++;
      if (req_ready !== 1'b1)
        $display("FAIL b2b_ready%0d got %b exp 1", i, req_ready);
      else pass_cnt++;
      @(posedge clk); #1;
      total_cnt++;
      if (rsp_valid !== 1'b1 || rsp_rs1_data !== e1 ||
          rsp_rs2_data !== e2)
        $display("FAIL b2b_rsp%0d got %b %h/%h exp 1 %h/%h",
                 i, rsp_valid, rsp_rs1_data, rsp_rs2_data, e1, e2);
      else pass_cnt++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk); #1;
    total_cnt++;
    if (rsp_valid !== 1'b0)
      $display("FAIL b2b_drain got %b exp 0", rsp_valid);
    else pass_cnt++;
  endtask

  task automatic test_set_wins();
    do_wb(5'd3, 32'h33);
    @(negedge clk);
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h77;
    req_valid = 1'b1; req_rs1 = 5'd0; req_rs2 = 5'd0;
    req_rd_alloc = 1'b1; req_rd = 5'd3;
    #1;
    total_cnt++;
    if (req_ready !== 1'b1)
      $display("FAIL setwin_alloc got %b exp 1", req_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    @(negedge clk);
    wb_en = 1'b0; req_rd_alloc = 1'b0; req_rs1 = 5'd3;
    #1;
    total_cnt++;
    if (req_ready !== 1'b0)
      $display("FAIL setwin_stall got %b exp 0", req_ready);
    else pass_cnt++;
    @(negedge clk);
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h99;
    #1;
    total_cnt++;
    if (req_ready !== 1'b1)
      $display("FAIL setwin_release got %b exp 1", req_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (rsp_rs1_data !== 32'h99)
      $display("FAIL setwin_data got %h exp 00000099", rsp_rs1_data);
    else pass_cnt++;
    @(negedge clk);
    wb_en = 1'b0; req_valid = 1'b0;
  endtask

  task automatic test_self_alloc();
    @(negedge clk);
    req_valid = 1'b1; req_rs1 = 5'd5; req_rs2 = 5'd0;
    req_rd_alloc = 1'b1; req_rd = 5'd5;
    #1;
    total_cnt++;
    if (req_ready !== 1'b1)
      $display("FAIL self_ready got %b exp 1", req_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (rsp_rs1_data !== 32'hDEADBEEF)
      $display("FAIL self_data got %h exp deadbeef", rsp_rs1_data);
    else pass_cnt++;
    @(negedge clk);
    req_rd_alloc = 1'b0;
    #1;
    total_cnt++;
    if (req_ready !== 1'b0)
      $display("FAIL self_stall got %b exp 0", req_ready);
    else pass_cnt++;
    @(negedge clk);
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
    @(posedge clk); #1;
    @(negedge clk);
    wb_en = 1'b0; req_valid = 1'b0;
  endtask

  task automatic test_x0();
    do_wb(5'd0, 32'hFFFF);
    @(negedge clk);
    req_valid = 1'b1; req_rs1 = 5'd0; req_rs2 = 5'd0;
    req_rd_alloc = 1'b1; req_rd = 5'd0;
    @(posedge clk); #1;
    total_cnt++;
    if (rsp_valid !== 1'b1 || rsp_rs1_data !== 32'h0 ||
        rsp_rs2_data !== 32'h0)
      $display("FAIL x0_data got %b %h/%h exp 1 0/0",
               rsp_valid, rsp_rs1_data, rsp_rs2_data);
    else pass_cnt++;
    @(negedge clk);
    req_rd_alloc = 1'b0;
    #1;
    total_cnt++;
    if (req_ready !== 1'b1)
      $display("FAIL x0_nostall got %b exp 1", req_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    do_wb(5'd12, 32'hC0DE);
    @(negedge clk);
    req_valid = 1'b1; req_rs1 = 5'd5; req_rs2 = 5'd0;
    req_rd_alloc = 1'b1; req_rd = 5'd12; rsp_ready = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if (rsp_valid !== 1'b1)
      $display("FAIL arst_full got %b exp 1", rsp_valid);
    else pass_cnt++;
    @(negedge clk);
    req_valid = 1'b0; req_rd_alloc = 1'b0; rsp_ready = 1'b0;
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    total_cnt++;
    if (rsp_valid !== 1'b0 || rsp_rs1_data !== 32'h0)
      $display("FAIL arst_clear got %b %h exp 0 0",
               rsp_valid, rsp_rs1_data);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b1; req_valid = 1'b1;
    req_rs1 = 5'd12; req_rs2 = 5'd0;
    #1;
    total_cnt++;
    if (req_ready !== 1'b1)
      $display("FAIL arst_nostall got %b exp 1", req_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (rsp_valid !== 1'b1 || rsp_rs1_data !== 32'hC0DE)
      $display("FAIL arst_data got %b %h exp 1 0000c0de",
               rsp_valid, rsp_rs1_data);
    else pass_cnt++;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  initial begin
    pass_cnt = 0; total_cnt = 0;
    rst = 1'b0; req_valid = 1'b0; req_rs1 = '0; req_rs2 = '0;
    req_rd_alloc = 1'b0; req_rd = '0; rsp_ready = 1'b1;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    test_reset();
    test_basic();
    test_hazard();
    test_stall();
    test_back_to_back();
    test_set_wins();
    test_self_alloc();
    test_x0();
    test_async_reset();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
